// File: rtl/cycle_delay_line.sv
// Programmable-latency launch path: a word sampled on one edge is re-issued from q_out dly_r edges later.
// Optional DLY_SPECIFY_EN adds a simulation-only specify block (CLK2Q on q_out/out_valid).
module cycle_delay_line #(
  parameter int N       = 8,
  parameter int MAX_DLY = 16,
  parameter int DEF_DLY = 1,
  parameter int DLY_W   = $clog2(MAX_DLY) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [DLY_W-1:0] dly_cfg,
  input  logic             in_valid,
  input  logic [N-1:0]     d_in,
  output logic             out_valid,
  output logic [N-1:0]     q_out,
  output logic             primed,
  output logic             cfg_err
);

  localparam int PTR_W = $clog2(MAX_DLY);

  typedef enum logic {FILL, RUN} state_t;

  state_t             state, state_nxt;
  logic [DLY_W-1:0]   dly_r, fill_cnt, fill_nxt;
  logic [DLY_W-1:0]   dly_clamped;
  logic               clamp_err;
  logic [PTR_W-1:0]   wr_ptr, rd_idx;
  logic [DLY_W:0]     rd_sum;
  logic [MAX_DLY-1:0] tag;
  logic [N-1:0]       mem [MAX_DLY];
  logic               rd_vld;
  logic [N-1:0]       rd_dat;

  always_comb begin
    dly_clamped = dly_cfg;
    clamp_err   = 1'b0;
    if (dly_cfg == '0) begin
      dly_clamped = DLY_W'(1);
      clamp_err   = 1'b1;
    end else if (dly_cfg > DLY_W'(MAX_DLY)) begin
      dly_clamped = DLY_W'(MAX_DLY);
      clamp_err   = 1'b1;
    end
  end

  // Output register loads the word written dly_r-1 edges ago; at dly_r=1 that is
  // the word being written now, so it bypasses the buffer.
  always_comb begin
    rd_sum = (DLY_W+1)'(wr_ptr) + (DLY_W+1)'(MAX_DLY + 1) - (DLY_W+1)'(dly_r);
    if (rd_sum >= (DLY_W+1)'(MAX_DLY))
      rd_sum = rd_sum - (DLY_W+1)'(MAX_DLY);
    rd_idx = PTR_W'(rd_sum);
    if (rd_idx == wr_ptr) begin
      rd_vld = in_valid;
      rd_dat = d_in;
    end else begin
      rd_vld = tag[rd_idx];
      rd_dat = mem[rd_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    if (cfg_load) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else if (state == FILL) begin
      if (fill_cnt == dly_r - DLY_W'(1))
        state_nxt = RUN;
      else
        fill_nxt = fill_cnt + DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      dly_r     <= DLY_W'(DEF_DLY);
      tag       <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      q_out     <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      wr_ptr   <= (wr_ptr == PTR_W'(MAX_DLY - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (cfg_load) begin
        dly_r     <= dly_clamped;
        tag       <= '0;
        out_valid <= 1'b0;
        cfg_err   <= cfg_err | clamp_err;
      end else begin
        tag[wr_ptr] <= in_valid;
        out_valid   <= rd_vld;
        if (rd_vld)
          q_out <= rd_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !cfg_load && in_valid)
      mem[wr_ptr] <= d_in;
  end

  assign primed = (state == RUN);

`ifdef DLY_SPECIFY_EN
  specify
    specparam CLK2Q = 3;
    (posedge clk => (q_out +: d_in)) = CLK2Q;
    (posedge clk => (out_valid +: in_valid)) = CLK2Q;
  endspecify
`else
`endif

endmodule
